// File: rtl/vga_pmod_receiver.sv
// Receive-side decoder for the TinyVGA PMOD bus: recovers sync timing, pixel
// coordinates and colour, and produces a per-frame CRC-16 plus timing-error flags.
module vga_pmod_receiver #(
  parameter int H_ACTIVE = 640,
  parameter int H_START  = 144,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_START  = 35,
  parameter int V_TOTAL  = 525,
  parameter int SYNC_NEG = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  pmod,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [5:0]  pix_rgb,
  output logic        frame_done,
  output logic [15:0] frame_crc,
  output logic        line_len_err,
  output logic        frame_len_err
);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_LO     = 10'(H_START);
  localparam logic [9:0] H_HI     = 10'(H_START + H_ACTIVE);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_LO     = 10'(V_START);
  localparam logic [9:0] V_HI     = 10'(V_START + V_ACTIVE);
  localparam logic [9:0] CNT_MAX  = 10'd1023;
  localparam logic       SYNC_INV = (SYNC_NEG != 0);

  typedef enum logic {WAIT_FRAME, RUN} state_t;

  logic [7:0]  p1_q, p1_d, p2_q, p2_d;
  logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic        hs_seen_q, hs_seen_d;
  logic        vs_pend_q, vs_pend_d;
  state_t      state_q, state_d;
  logic [15:0] crc_q, crc_d;
  logic        pix_valid_q, pix_valid_d;
  logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [5:0]  pix_rgb_q, pix_rgb_d;
  logic        frame_done_q, frame_done_d;
  logic [15:0] frame_crc_q, frame_crc_d;
  logic        line_len_err_q, line_len_err_d;
  logic        frame_len_err_q, frame_len_err_d;

  logic       hs1, hs2, vs1, vs2;
  logic       hs_edge, vs_edge, frame_start, in_window, pix_hit;
  logic [5:0] sample_rgb;

  // h_cnt/v_cnt describe the sample currently held in p2.
  assign hs1         = p1_q[7] ^ SYNC_INV;
  assign hs2         = p2_q[7] ^ SYNC_INV;
  assign vs1         = p1_q[3] ^ SYNC_INV;
  assign vs2         = p2_q[3] ^ SYNC_INV;
  assign hs_edge     = hs1 & ~hs2;
  assign vs_edge     = vs1 & ~vs2;
  assign frame_start = hs_edge & (vs_pend_q | vs_edge);
  assign sample_rgb  = {p2_q[0], p2_q[4], p2_q[1], p2_q[5], p2_q[2], p2_q[6]};
  assign in_window   = (h_cnt_q >= H_LO) && (h_cnt_q < H_HI) &&
                       (v_cnt_q >= V_LO) && (v_cnt_q < V_HI);
  assign pix_hit     = (state_q == RUN) && in_window && !frame_start;

  // CRC-16-CCITT, MSB first, one byte per call.
  function automatic logic [15:0] crc_byte(input logic [15:0] crc_in, input logic [7:0] data);
    logic [15:0] c;
    c = crc_in ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  always_comb begin
    p1_d            = pmod;
    p2_d            = p1_q;
    h_cnt_d         = (h_cnt_q == CNT_MAX) ? h_cnt_q : h_cnt_q + 10'd1;
    v_cnt_d         = v_cnt_q;
    hs_seen_d       = hs_seen_q | hs_edge;
    vs_pend_d       = vs_pend_q | vs_edge;
    line_len_err_d  = line_len_err_q;
    state_d         = state_q;
    crc_d           = crc_q;
    frame_done_d    = 1'b0;
    frame_crc_d     = frame_crc_q;
    frame_len_err_d = frame_len_err_q;
    pix_valid_d     = pix_hit;
    pix_x_d         = pix_x_q;
    pix_y_d         = pix_y_q;
    pix_rgb_d       = pix_rgb_q;

    if (hs_edge) begin
      h_cnt_d   = 10'd0;
      vs_pend_d = 1'b0;
      if (hs_seen_q && (h_cnt_q != H_LAST)) line_len_err_d = 1'b1;
      if (vs_pend_q || vs_edge) v_cnt_d = 10'd0;
      else if (v_cnt_q != CNT_MAX) v_cnt_d = v_cnt_q + 10'd1;
    end

    // The first frame start after reset only arms RUN; the partial frame is discarded.
    if (frame_start) begin
      state_d = RUN;
      crc_d   = 16'hFFFF;
      if (state_q == RUN) begin
        frame_done_d = 1'b1;
        frame_crc_d  = crc_q;
        if (v_cnt_q != V_LAST) frame_len_err_d = 1'b1;
      end
    end else if (pix_hit) begin
      crc_d = crc_byte(crc_q, {2'b00, sample_rgb});
    end

    if (pix_hit) begin
      pix_x_d   = h_cnt_q - H_LO;
      pix_y_d   = v_cnt_q - V_LO;
      pix_rgb_d = sample_rgb;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p1_q            <= 8'h00;
      p2_q            <= 8'h00;
      h_cnt_q         <= 10'd0;
      v_cnt_q         <= 10'd0;
      hs_seen_q       <= 1'b0;
      vs_pend_q       <= 1'b0;
      state_q         <= WAIT_FRAME;
      crc_q           <= 16'hFFFF;
      pix_valid_q     <= 1'b0;
      pix_x_q         <= 10'd0;
      pix_y_q         <= 10'd0;
      pix_rgb_q       <= 6'd0;
      frame_done_q    <= 1'b0;
      frame_crc_q     <= 16'h0000;
      line_len_err_q  <= 1'b0;
      frame_len_err_q <= 1'b0;
    end else begin
      p1_q            <= p1_d;
      p2_q            <= p2_d;
      h_cnt_q         <= h_cnt_d;
      v_cnt_q         <= v_cnt_d;
      hs_seen_q       <= hs_seen_d;
      vs_pend_q       <= vs_pend_d;
      state_q         <= state_d;
      crc_q           <= crc_d;
      pix_valid_q     <= pix_valid_d;
      pix_x_q         <= pix_x_d;
      pix_y_q         <= pix_y_d;
      pix_rgb_q       <= pix_rgb_d;
      frame_done_q    <= frame_done_d;
      frame_crc_q     <= frame_crc_d;
      line_len_err_q  <= line_len_err_d;
      frame_len_err_q <= frame_len_err_d;
    end
  end

  assign pix_valid     = pix_valid_q;
  assign pix_x         = pix_x_q;
  assign pix_y         = pix_y_q;
  assign pix_rgb       = pix_rgb_q;
  assign frame_done    = frame_done_q;
  assign frame_crc     = frame_crc_q;
  assign line_len_err  = line_len_err_q;
  assign frame_len_err = frame_len_err_q;

endmodule

// File: tb/tb_vga_pmod_receiver.sv
// Bench for vga_pmod_receiver on a reduced video timing: drives whole frames on
// the PMOD bus and checks pixels, frame CRCs and error flags against a scoreboard.
module tb_vga_pmod_receiver;
  localparam int HA = 16, HSW = 4, HST = 6, HT = 24;
  localparam int VA = 8, VSW = 1, VST = 3, VT = 12;
  localparam int P = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  pmod = 8'h00;
  logic        pix_valid, frame_done, line_len_err, frame_len_err;
  logic [9:0]  pix_x, pix_y;
  logic [5:0]  pix_rgb;
  logic [15:0] frame_crc;

  always #(P/2) clk = ~clk;

  vga_pmod_receiver #(
    .H_ACTIVE(HA), .H_START(HST), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_START(VST), .V_TOTAL(VT), .SYNC_NEG(1)
  ) dut (
    .clk(clk), .reset(reset), .pmod(pmod),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .frame_done(frame_done), .frame_crc(frame_crc),
    .line_len_err(line_len_err), .frame_len_err(frame_len_err)
  );

  int errors = 0, checks = 0;
  logic [25:0] exp_q[$];
  logic [15:0] crc_q[$];

  bit          tb_run = 0, hs_seen = 0;
  int          prev_len = 0, frame_lines = 0;
  logic [15:0] crc_model = 16'hFFFF, last_crc_exp = 16'h0000;
  logic        exp_line_err = 0, exp_frame_err = 0;
  int          mode = 0, wx = 0, wy = 0;
  logic [5:0]  solid_rgb = 6'd0;
  int          valid_cnt = 0, white_cnt = 0, done_cnt = 0, d0 = 0;
  logic [9:0]  white_x = 0, white_y = 0;
  time         white_t = 0, white_drv_t = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [7:0] b);
    logic fb;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ b[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  // Bus syncs are active-low; rgb is {R1,R0,G1,G0,B1,B0}.
  function automatic logic [7:0] enc(input logic hs_on, input logic vs_on, input logic [5:0] rgb);
    return {~hs_on, rgb[0], rgb[2], rgb[4], ~vs_on, rgb[1], rgb[3], rgb[5]};
  endfunction

  function automatic logic [5:0] colour(input int x, input int y);
    if (mode == 0) return solid_rgb;
    if (mode == 1) return (x == wx && y == wy) ? 6'h3F : 6'h00;
    return 6'($urandom_range(0, 63));
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (pix_valid) begin
        valid_cnt++;
        if (pix_rgb == 6'h3F) begin
          white_cnt++;
          white_x = pix_x;
          white_y = pix_y;
          white_t = $time;
        end
        chk("pix_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("pix_xyrgb", {6'd0, pix_x, pix_y, pix_rgb}, {6'd0, exp_q.pop_front()});
      end
      if (frame_done) begin
        done_cnt++;
        chk("crc_pending", 32'(crc_q.size() != 0), 32'd1);
        if (crc_q.size() != 0) begin
          last_crc_exp = crc_q.pop_front();
          chk("frame_crc", {16'd0, frame_crc}, {16'd0, last_crc_exp});
        end
      end
    end
  end

  task automatic drive_line(input int len, input bit vs_on, input bit first, input int row, input int rst_pos);
    for (int p = 0; p < len; p++) begin
      logic [5:0] rgb;
      bit vis;
      @(negedge clk);
      reset = (rst_pos >= 0) && (p >= rst_pos) && (p < rst_pos + 3);
      if (p == 0) begin
        if (hs_seen && prev_len != HT) exp_line_err = 1'b1;
        hs_seen  = 1;
        prev_len = len;
        if (first && vs_on) begin
          if (tb_run) begin
            crc_q.push_back(crc_model);
            if (frame_lines != VT) exp_frame_err = 1'b1;
          end
          tb_run      = 1;
          crc_model   = 16'hFFFF;
          frame_lines = 0;
        end
        frame_lines++;
      end
      if (rst_pos >= 0 && p == rst_pos) begin
        tb_run = 0; hs_seen = 0; exp_line_err = 0; exp_frame_err = 0;
        last_crc_exp = 16'h0000;
        exp_q.delete();
        crc_q.delete();
      end
      if (rst_pos >= 0 && p == rst_pos + 1) begin
        chk("rst_mid_valid", 32'(pix_valid), 32'd0);
        chk("rst_mid_crc", {16'd0, frame_crc}, 32'd0);
        chk("rst_mid_line_err", 32'(line_len_err), 32'd0);
        chk("rst_mid_frame_err", 32'(frame_len_err), 32'd0);
      end
      vis = (p >= HST) && (p < HST + HA) && (row >= VST) && (row < VST + VA);
      rgb = vis ? colour(p - HST, row - VST) : 6'($urandom_range(0, 63));
      if (vis && tb_run) begin
        exp_q.push_back({10'(p - HST), 10'(row - VST), rgb});
        crc_model = crc_ref(crc_model, {2'b00, rgb});
        if (mode == 1 && rgb == 6'h3F) white_drv_t = $time;
      end
      pmod = enc(p < HSW, vs_on, rgb);
    end
  endtask

  task automatic drive_frame(input int nlines, input int short_row, input int rst_row);
    for (int r = 0; r < nlines; r++) begin
      drive_line((r == short_row) ? HT - 1 : HT, r < VSW, r == 0, r, (r == rst_row) ? 1 : -1);
    end
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_line_err"}, 32'(line_len_err), 32'(exp_line_err));
    chk({tag, "_frame_err"}, 32'(frame_len_err), 32'(exp_frame_err));
    chk({tag, "_crc_hold"}, {16'd0, frame_crc}, {16'd0, last_crc_exp});
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pmod = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    chk("rst_valid", 32'(pix_valid), 32'd0);
    chk("rst_x", {22'd0, pix_x}, 32'd0);
    chk("rst_y", {22'd0, pix_y}, 32'd0);
    chk("rst_rgb", {26'd0, pix_rgb}, 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_crc", {16'd0, frame_crc}, 32'd0);
    chk("rst_line_err", 32'(line_len_err), 32'd0);
    chk("rst_frame_err", 32'(frame_len_err), 32'd0);
    reset = 1'b0;
    pmod  = enc(1'b0, 1'b0, 6'd0);

    // Lines without any frame start: nothing may be reported yet.
    mode = 2;
    drive_line(HT, 0, 0, VST + 1, -1);
    drive_line(HT, 0, 0, VST + 2, -1);

    mode = 0;
    solid_rgb = 6'b110001;
    for (int f = 0; f < 3; f++) begin
      valid_cnt = 0;
      drive_frame(VT, -1, -1);
      chk("solid_valid_cnt", 32'(valid_cnt), 32'(HA * VA));
      chk("solid_done_cnt", 32'(done_cnt), 32'(f));
      check_flags("solid");
    end

    mode = 1; wx = HA - 1; wy = VA - 1; white_cnt = 0;
    drive_frame(VT, -1, -1);
    chk("white_cnt", 32'(white_cnt), 32'd1);
    chk("white_x", {22'd0, white_x}, 32'(HA - 1));
    chk("white_y", {22'd0, white_y}, 32'(VA - 1));
    // Driven at negedge t, captured at t+P/2, visible after two more edges, read at t+3P.
    chk("white_latency", 32'(white_t - white_drv_t), 32'(3 * P));

    mode = 2;
    drive_frame(VT, -1, -1);
    check_flags("random");

    drive_frame(VT - 1, -1, -1);
    drive_frame(VT, -1, -1);
    chk("short_frame_err", 32'(frame_len_err), 32'd1);
    chk("short_frame_line_err", 32'(line_len_err), 32'd0);
    check_flags("short_frame");

    drive_frame(VT, 5, -1);
    chk("short_line_err", 32'(line_len_err), 32'd1);
    drive_frame(VT, -1, -1);
    chk("short_line_sticky", 32'(line_len_err), 32'd1);
    check_flags("short_line");

    drive_frame(VT, -1, -1);
    drive_frame(VT, -1, 5);
    d0 = done_cnt;
    drive_frame(VT, -1, -1);
    chk("post_rst_no_done", 32'(done_cnt), 32'(d0));
    drive_frame(VT, -1, -1);
    chk("post_rst_first_done", 32'(done_cnt), 32'(d0 + 1));
    check_flags("post_rst");

    drive_line(HT, 1, 1, 0, -1);
    drive_line(HT, 0, 0, 1, -1);
    repeat (5) @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("crc_q_drained", 32'(crc_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
